// File: rtl/arrow_queue.sv
// Beat-driven arrow target queue: spawns one direction per beat into a small FIFO,
// judges button presses against the oldest pending arrow and keeps hit/miss tallies.
module arrow_queue #(
  parameter int         DEPTH       = 4,
  parameter int         SPAWN_DIV   = 25000000,
  parameter int         MAX_MISS    = 10,
  parameter logic [1:0] PLAY_STATE  = 2'd1,
  parameter logic [1:0] RESET_STATE = 2'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic [4:0] random_arrow,
  input  logic [3:0] btn,
  output logic [1:0] head_dir,
  output logic       head_valid,
  output logic [3:0] queue_count,
  output logic [7:0] score,
  output logic [3:0] miss,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(SPAWN_DIV - 1);
  localparam logic [3:0]       DEPTH_C   = 4'(DEPTH);
  localparam logic [3:0]       MAX_C     = 4'(MAX_MISS);

  logic [1:0]       mem [DEPTH];
  logic [CNT_W-1:0] beat_reg, beat_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [3:0]       count_reg, count_next;
  logic [1:0]       head_reg, head_next;
  logic [7:0]       score_reg, score_next;
  logic [3:0]       miss_reg, miss_next;
  logic             hit_reg, miss_p_reg, over_reg;

  logic active, spawn, press, hit, wrong, overflow, pop, miss_ev;

  // Only the low two bits select a direction; the rest of the LFSR word is don't-care.
  logic unused_arrow_bits;
  assign unused_arrow_bits = ^random_arrow[4:2];

  always_comb begin
    active   = (state == PLAY_STATE) && !over_reg;
    spawn    = active && (beat_reg == BEAT_LAST);
    press    = active && (count_reg != 4'd0) && (btn != 4'd0);
    hit      = press && (btn == (4'b0001 << head_reg));
    wrong    = press && !hit;
    // A press in the spawn cycle makes room, so overflow only applies without one.
    overflow = spawn && (count_reg == DEPTH_C) && !press;
    pop      = press || overflow;
    miss_ev  = wrong || overflow;

    rd_ptr_next = pop   ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    wr_ptr_next = spawn ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    count_next  = count_reg + {3'b000, spawn} - {3'b000, pop};

    // Bypass the incoming arrow when it lands exactly at the new head slot.
    head_next = 2'd0;
    if (count_next != 4'd0) begin
      if (spawn && (rd_ptr_next == wr_ptr_reg))
        head_next = random_arrow[1:0];
      else
        head_next = mem[rd_ptr_next];
    end

    score_next = (hit && score_reg != 8'hFF) ? score_reg + 8'd1 : score_reg;
    miss_next  = (miss_ev && miss_reg < MAX_C) ? miss_reg + 4'd1 : miss_reg;

    beat_next = beat_reg;
    if (active)
      beat_next = spawn ? '0 : beat_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (spawn)
      mem[wr_ptr_reg] <= random_arrow[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || state == RESET_STATE) begin
      beat_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      score_reg  <= '0;
      miss_reg   <= '0;
      hit_reg    <= 1'b0;
      miss_p_reg <= 1'b0;
      over_reg   <= 1'b0;
    end else begin
      beat_reg   <= beat_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      score_reg  <= score_next;
      miss_reg   <= miss_next;
      hit_reg    <= hit;
      miss_p_reg <= miss_ev;
      over_reg   <= over_reg || (miss_next == MAX_C);
    end
  end

  assign head_dir    = head_reg;
  assign head_valid  = (count_reg != 4'd0);
  assign queue_count = count_reg;
  assign score       = score_reg;
  assign miss        = miss_reg;
  assign hit_pulse   = hit_reg;
  assign miss_pulse  = miss_p_reg;
  assign game_over   = over_reg;

endmodule

// File: tb/tb_arrow_queue.sv
// Directed bench for arrow_queue with SPAWN_DIV=8, DEPTH=4, MAX_MISS=3.
module tb_arrow_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state;
  logic [4:0] random_arrow;
  logic [3:0] btn;
  logic [1:0] head_dir;
  logic       head_valid;
  logic [3:0] queue_count;
  logic [7:0] score;
  logic [3:0] miss;
  logic       hit_pulse, miss_pulse, game_over;

  int checks   = 0;
  int failures = 0;

  arrow_queue #(.DEPTH(4), .SPAWN_DIV(8), .MAX_MISS(3), .PLAY_STATE(2'd1), .RESET_STATE(2'd2)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .random_arrow(random_arrow), .btn(btn),
    .head_dir(head_dir), .head_valid(head_valid), .queue_count(queue_count),
    .score(score), .miss(miss), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Synchronous clear through the state bus, then back into play with beat counter at 0.
  task automatic restart();
    state = 2'd2;
    tick(1);
    state = 2'd1;
  endtask

  initial begin
    rst_n = 1'b1; state = 2'd0; random_arrow = 5'd13; btn = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_count", queue_count, 0);
    check("rst_valid", head_valid, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss, 0);
    check("rst_over", game_over, 0);
    tick(2);
    rst_n = 1'b1;
    state = 2'd1;

    // 1: spawns every 8 cycles, overflow drop at the 5th
    tick(7);
    check("t1_no_spawn_yet", queue_count, 0);
    tick(1);
    check("t1_first_spawn", queue_count, 1);
    check("t1_first_head", head_dir, 1);
    tick(24);
    check("t1_full", queue_count, 4);
    check("t1_head", head_dir, 1);
    tick(7);
    check("t1_miss_before", miss, 0);
    tick(1);
    check("t1_overflow_miss", miss, 1);
    check("t1_overflow_pulse", miss_pulse, 1);
    check("t1_overflow_count", queue_count, 4);
    tick(1);
    check("t1_pulse_width", miss_pulse, 0);

    // 2: correct press on a single left arrow
    restart();
    check("t2_cleared_miss", miss, 0);
    random_arrow = 5'd14;
    tick(8);
    check("t2_head_left", head_dir, 2);
    btn = 4'b0100;
    tick(1);
    btn = 4'd0;
    check("t2_score", score, 1);
    check("t2_hit_pulse", hit_pulse, 1);
    check("t2_valid", head_valid, 0);
    check("t2_head_zero", head_dir, 0);
    tick(1);
    check("t2_hit_width", hit_pulse, 0);

    // 3: multi-bit press is a miss
    restart();
    random_arrow = 5'd12;
    tick(8);
    check("t3_head_up", head_dir, 0);
    check("t3_valid", head_valid, 1);
    btn = 4'b0011;
    tick(1);
    btn = 4'd0;
    check("t3_miss", miss, 1);
    check("t3_score", score, 0);
    check("t3_miss_pulse", miss_pulse, 1);
    check("t3_count", queue_count, 0);

    // 4: correct press coinciding with a spawn on a full queue
    restart();
    random_arrow = 5'd13;
    tick(32);
    check("t4_full", queue_count, 4);
    random_arrow = 5'd15;
    tick(7);
    btn = 4'b0010;
    tick(1);
    check("t4_score", score, 1);
    check("t4_miss", miss, 0);
    check("t4_count", queue_count, 4);
    check("t4_no_miss_pulse", miss_pulse, 0);
    tick(3);
    btn = 4'd0;
    check("t4_drain_count", queue_count, 1);
    check("t4_drain_score", score, 4);
    check("t4_tail", head_dir, 3);

    // 5: three wrong presses end the game; everything then freezes
    restart();
    random_arrow = 5'd13;
    tick(32);
    btn = 4'b0001;
    tick(2);
    check("t5_miss2", miss, 2);
    check("t5_not_over", game_over, 0);
    tick(1);
    check("t5_miss3", miss, 3);
    check("t5_over", game_over, 1);
    check("t5_count", queue_count, 1);
    btn = 4'b0010;
    tick(1);
    check("t5_frozen_score", score, 0);
    check("t5_frozen_hit", hit_pulse, 0);
    btn = 4'd0;
    tick(16);
    check("t5_frozen_count", queue_count, 1);
    check("t5_frozen_miss", miss, 3);
    state = 2'd2;
    tick(1);
    state = 2'd1;
    check("t5_clr_miss", miss, 0);
    check("t5_clr_over", game_over, 0);
    check("t5_clr_count", queue_count, 0);

    // 6: pause holds the beat counter and ignores presses; async reset
    random_arrow = 5'd13;
    tick(13);
    check("t6_pre_pause", queue_count, 1);
    state = 2'd3;
    btn = 4'b0010;
    tick(20);
    btn = 4'd0;
    check("t6_pause_count", queue_count, 1);
    check("t6_pause_score", score, 0);
    state = 2'd1;
    tick(2);
    check("t6_resume_hold", queue_count, 1);
    tick(1);
    check("t6_resume_spawn", queue_count, 2);
    btn = 4'b0010;
    tick(1);
    btn = 4'd0;
    check("t6_score", score, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count", queue_count, 0);
    check("t6_async_score", score, 0);
    check("t6_async_valid", head_valid, 0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
